cart_bus_arbiter: RTL and testbench

- Shares the external cartridge bus (address, data, rd, wr, cs) between two masters: the Game Boy core (port C) and the UART debug/loader master (port D).
- Sequences each access as SETUP → STROBE → HOLD with parameterised cycle counts.
- Sits between the boy core / debug logic and the top-level cartridge pins. Top level inverts rd, wr and cs to pin polarity and tri-states the data bus using bus_oe.

---
 rtl/cart_bus_pkg.sv | 30 +++
 rtl/cart_cycle_timer.sv | 27 ++
 rtl/cart_bus_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_cart_bus_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cart_bus_pkg.sv
// Shared types and constants for the cartridge bus arbiter.
// State encoding, chip-select region and owner codes live here.
package cart_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    localparam logic [2:0] CS_REGION = 3'b101;

    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DBG  = 1'b1;

    // Timer holds N-1, so it needs enough bits for the largest phase minus one.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    function automatic logic is_cart_ram(input logic [15:0] addr);
        return addr[15:13] == CS_REGION;
    endfunction

endpackage

// File: rtl/cart_cycle_timer.sv
// Loadable down-counter shared by the SETUP, STROBE and HOLD phases.
// done is high whenever the count has reached zero.
module cart_cycle_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/cart_bus_arbiter.sv
// Arbitrates the cartridge bus between the core and the debug master and
// sequences each access as SETUP -> STROBE -> HOLD.
module cart_bus_arbiter
    import cart_bus_pkg::*;
#(
    parameter int SETUP_CYCLES   = 1,
    parameter int STROBE_CYCLES  = 4,
    parameter int HOLD_CYCLES    = 1,
    parameter int MAX_CORE_BURST = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        core_req,
    input  logic        core_we,
    input  logic [15:0] core_addr,
    input  logic [7:0]  core_wdata,
    output logic        core_ack,
    output logic [7:0]  core_rdata,

    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic [15:0] dbg_addr,
    input  logic [7:0]  dbg_wdata,
    output logic        dbg_ack,
    output logic [7:0]  dbg_rdata,

    input  logic        halt,

    output logic [15:0] bus_a,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din,
    output logic        bus_oe,
    output logic        bus_rd,
    output logic        bus_wr,
    output logic        bus_cs,
    output logic        busy,
    output logic        owner
);

    localparam int CW = cnt_width(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES);
    localparam int SW = $clog2(MAX_CORE_BURST + 1);

    localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LD   = CW'(HOLD_CYCLES - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_CORE_BURST);

    state_t        state;
    logic          we_q;
    logic [SW-1:0] streak;

    logic          core_elig;
    logic          dbg_elig;
    logic          streak_full;
    logic          pick_dbg;
    logic          grant;
    logic [15:0]   g_addr;
    logic [7:0]    g_wdata;
    logic          g_we;

    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_done;

    assign core_elig   = core_req & ~halt;
    assign dbg_elig    = dbg_req;
    assign streak_full = (streak == STREAK_MAX);
    assign pick_dbg    = dbg_elig & (~core_elig | streak_full);

    // The cycle carrying an ack never grants, so a requester can drop req.
    assign grant = (state == ST_IDLE)
                 & ~(core_ack | dbg_ack)
                 & (core_elig | dbg_elig);

    assign g_addr  = pick_dbg ? dbg_addr  : core_addr;
    assign g_wdata = pick_dbg ? dbg_wdata : core_wdata;
    assign g_we    = pick_dbg ? dbg_we    : core_we;

    assign busy = (state != ST_IDLE);

    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = '0;
        unique case (state)
            ST_IDLE: begin
                if (grant) begin
                    tmr_load = 1'b1;
                    tmr_val  = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = STROBE_LD;
                end
            end
            ST_STROBE: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    tmr_val  = HOLD_LD;
                end
            end
            default: begin
                tmr_load = 1'b0;
                tmr_val  = '0;
            end
        endcase
    end

    cart_cycle_timer #(
        .W(CW)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            we_q       <= 1'b0;
            streak     <= '0;
            owner      <= OWN_CORE;
            bus_a      <= '0;
            bus_dout   <= '0;
            bus_oe     <= 1'b0;
            bus_rd     <= 1'b0;
            bus_wr     <= 1'b0;
            bus_cs     <= 1'b0;
            core_ack   <= 1'b0;
            dbg_ack    <= 1'b0;
            core_rdata <= '0;
            dbg_rdata  <= '0;
        end else begin
            core_ack <= 1'b0;
            dbg_ack  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (!dbg_req) begin
                        streak <= '0;
                    end
                    if (grant) begin
                        state    <= ST_SETUP;
                        owner    <= pick_dbg ? OWN_DBG : OWN_CORE;
                        we_q     <= g_we;
                        bus_a    <= g_addr;
                        bus_dout <= g_wdata;
                        bus_cs   <= is_cart_ram(g_addr);
                        bus_oe   <= g_we;
                        if (pick_dbg) begin
                            streak <= '0;
                        end else if (dbg_req && !streak_full) begin
                            streak <= streak + 1'b1;
                        end
                    end
                end
                ST_SETUP: begin
                    if (tmr_done) begin
                        state  <= ST_STROBE;
                        bus_rd <= ~we_q;
                        bus_wr <= we_q;
                    end
                end
                ST_STROBE: begin
                    if (tmr_done) begin
                        state  <= ST_HOLD;
                        bus_rd <= 1'b0;
                        bus_wr <= 1'b0;
                        if (!we_q) begin
                            if (owner == OWN_DBG) begin
                                dbg_rdata <= bus_din;
                            end else begin
                                core_rdata <= bus_din;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (tmr_done) begin
                        state  <= ST_IDLE;
                        bus_cs <= 1'b0;
                        bus_oe <= 1'b0;
                        if (owner == OWN_DBG) begin
                            dbg_ack <= 1'b1;
                        end else begin
                            core_ack <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cart_bus_arbiter.sv
// Self-checking bench for cart_bus_arbiter at default parameters.
// Cycle i is observed on the falling edge after the i-th rising edge following the request.
module tb_cart_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we;
    logic [15:0] core_addr;
    logic [7:0]  core_wdata;
    logic        core_ack;
    logic [7:0]  core_rdata;
    logic        dbg_req, dbg_we;
    logic [15:0] dbg_addr;
    logic [7:0]  dbg_wdata;
    logic        dbg_ack;
    logic [7:0]  dbg_rdata;
    logic        halt;
    logic [15:0] bus_a;
    logic [7:0]  bus_dout;
    logic [7:0]  bus_din;
    logic        bus_oe, bus_rd, bus_wr, bus_cs;
    logic        busy, owner;

    int checks = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    logic       exp_own_q[$];

    always #5 clk = ~clk;

    cart_bus_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_rdata (core_rdata),
        .dbg_req    (dbg_req),
        .dbg_we     (dbg_we),
        .dbg_addr   (dbg_addr),
        .dbg_wdata  (dbg_wdata),
        .dbg_ack    (dbg_ack),
        .dbg_rdata  (dbg_rdata),
        .halt       (halt),
        .bus_a      (bus_a),
        .bus_dout   (bus_dout),
        .bus_din    (bus_din),
        .bus_oe     (bus_oe),
        .bus_rd     (bus_rd),
        .bus_wr     (bus_wr),
        .bus_cs     (bus_cs),
        .busy       (busy),
        .owner      (owner)
    );

    task automatic test_reset();
        rst = 1'b0;
        core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        halt = 0; bus_din = 8'hFF;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, owner, bus_rd, bus_wr, bus_oe, bus_cs, core_ack, dbg_ack} !== 8'h00) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=00000000",
                {busy, owner, bus_rd, bus_wr, bus_oe, bus_cs, core_ack, dbg_ack});
        end
        checks++;
        if ({bus_a, bus_dout, core_rdata, dbg_rdata} !== 40'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", {bus_a, bus_dout, core_rdata, dbg_rdata});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_core_read();
        core_we = 0; core_addr = 16'h0150; core_req = 1;
        exp_q.push_back(8'h3E);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); @(negedge clk);
            bus_din = (i >= 2 && i <= 5) ? 8'h3E : 8'hFF;
            checks++;
            if (bus_rd !== (i >= 2 && i <= 5)) begin
                failures++;
                $display("FAIL core_read_rd cyc=%0d got=%b", i, bus_rd);
            end
            checks++;
            if ({bus_cs, bus_wr, bus_oe} !== 3'b000) begin
                failures++;
                $display("FAIL core_read_cs_wr_oe cyc=%0d got=%b exp=000", i, {bus_cs, bus_wr, bus_oe});
            end
            checks++;
            if (core_ack !== (i == 7)) begin
                failures++;
                $display("FAIL core_read_ack cyc=%0d got=%b", i, core_ack);
            end
            if (i >= 1 && i <= 6) begin
                checks++;
                if (bus_a !== 16'h0150) begin
                    failures++;
                    $display("FAIL core_read_addr cyc=%0d got=%h exp=0150", i, bus_a);
                end
            end
            if (core_ack === 1'b1) begin
                core_req = 0;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL core_read_sb got=ack exp=no_pending");
                end else if (core_rdata !== exp_q[0]) begin
                    failures++;
                    $display("FAIL core_read_rdata got=%h exp=%h", core_rdata, exp_q[0]);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
        core_req = 0;
        bus_din = 8'hFF;
    endtask

    task automatic test_dbg_write();
        dbg_we = 1; dbg_addr = 16'hA000; dbg_wdata = 8'h5A; dbg_req = 1;
        exp_own_q.push_back(1'b1);
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); @(negedge clk);
            checks++;
            if ({bus_cs, bus_oe} !== {2{(i >= 1 && i <= 6)}}) begin
                failures++;
                $display("FAIL dbg_write_cs_oe cyc=%0d got=%b", i, {bus_cs, bus_oe});
            end
            checks++;
            if (bus_wr !== (i >= 2 && i <= 5)) begin
                failures++;
                $display("FAIL dbg_write_wr cyc=%0d got=%b", i, bus_wr);
            end
            checks++;
            if (bus_rd !== 1'b0) begin
                failures++;
                $display("FAIL dbg_write_rd cyc=%0d got=%b exp=0", i, bus_rd);
            end
            checks++;
            if ({dbg_ack, core_ack} !== {(i == 7), 1'b0}) begin
                failures++;
                $display("FAIL dbg_write_ack cyc=%0d got=%b", i, {dbg_ack, core_ack});
            end
            if (i >= 1 && i <= 6) begin
                checks++;
                if ({bus_a, bus_dout} !== {16'hA000, 8'h5A}) begin
                    failures++;
                    $display("FAIL dbg_write_bus cyc=%0d got=%h exp=a0005a", i, {bus_a, bus_dout});
                end
            end
            if (dbg_ack === 1'b1) begin
                dbg_req = 0;
                checks++;
                if (exp_own_q.size() == 0 || owner !== exp_own_q[0]) begin
                    failures++;
                    $display("FAIL dbg_write_owner got=%b", owner);
                end
                if (exp_own_q.size() != 0) void'(exp_own_q.pop_front());
            end
        end
        dbg_req = 0; dbg_we = 0;
    endtask

    task automatic test_arbitration();
        int n = 0;
        int cyc = 0;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) exp_own_q.push_back(1'b0);
            exp_own_q.push_back(1'b1);
        end
        core_we = 0; core_addr = 16'h0200;
        dbg_we = 0; dbg_addr = 16'h0300;
        core_req = 1; dbg_req = 1;
        while (n < 18 && cyc < 400) begin
            @(posedge clk); @(negedge clk);
            cyc++;
            if (core_ack === 1'b1 || dbg_ack === 1'b1) begin
                n++;
                checks++;
                if (exp_own_q.size() == 0) begin
                    failures++;
                    $display("FAIL arb_sb grant=%0d got=extra_ack", n);
                end else if ({dbg_ack, core_ack, owner} !==
                             {exp_own_q[0], ~exp_own_q[0], exp_own_q[0]}) begin
                    failures++;
                    $display("FAIL arb_order grant=%0d got=%b exp=%b", n,
                        {dbg_ack, core_ack, owner},
                        {exp_own_q[0], ~exp_own_q[0], exp_own_q[0]});
                end
                if (exp_own_q.size() != 0) void'(exp_own_q.pop_front());
                if (n == 18) begin
                    core_req = 0; dbg_req = 0;
                end
            end
        end
        core_req = 0; dbg_req = 0;
        checks++;
        if (n != 18) begin
            failures++;
            $display("FAIL arb_count got=%0d exp=18", n);
        end
        exp_own_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_halt();
        int n = 0;
        halt = 1;
        exp_own_q.push_back(1'b1);
        exp_own_q.push_back(1'b0);
        core_we = 0; core_addr = 16'h0400;
        dbg_we = 0; dbg_addr = 16'h0500;
        core_req = 1; dbg_req = 1;
        for (int i = 1; i <= 40 && n < 2; i++) begin
            @(posedge clk); @(negedge clk);
            if (i == 1) begin
                checks++;
                if (owner !== 1'b1) begin
                    failures++;
                    $display("FAIL halt_first_owner got=%b exp=1", owner);
                end
            end
            if (i == 3) halt = 0;
            if (core_ack === 1'b1 || dbg_ack === 1'b1) begin
                n++;
                checks++;
                if (exp_own_q.size() == 0 || dbg_ack !== exp_own_q[0]) begin
                    failures++;
                    $display("FAIL halt_order grant=%0d got_dbg_ack=%b", n, dbg_ack);
                end
                if (exp_own_q.size() != 0) void'(exp_own_q.pop_front());
                if (n == 2) begin
                    core_req = 0; dbg_req = 0;
                end
            end
        end
        core_req = 0; dbg_req = 0; halt = 0;
        checks++;
        if (n != 2) begin
            failures++;
            $display("FAIL halt_count got=%0d exp=2", n);
        end
        exp_own_q.delete();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        int acks = 0;
        core_we = 1; core_addr = 16'hA123; core_wdata = 8'hC3; core_req = 1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); @(negedge clk);
        end
        checks++;
        if ({bus_wr, bus_oe, bus_cs} !== 3'b111) begin
            failures++;
            $display("FAIL rstmid_pre got=%b exp=111", {bus_wr, bus_oe, bus_cs});
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({bus_wr, bus_oe, bus_cs, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL rstmid_ctrl got=%b exp=0000", {bus_wr, bus_oe, bus_cs, busy});
        end
        checks++;
        if (bus_a !== 16'h0000) begin
            failures++;
            $display("FAIL rstmid_addr got=%h exp=0000", bus_a);
        end
        core_req = 0; core_we = 0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); @(negedge clk);
            if (core_ack === 1'b1 || dbg_ack === 1'b1) acks++;
        end
        checks++;
        if (acks != 0) begin
            failures++;
            $display("FAIL rstmid_noack got=%0d exp=0", acks);
        end
        core_addr = 16'h4000; core_req = 1;
        exp_q.push_back(8'h77);
        for (int i = 1; i <= 9; i++) begin
            @(posedge clk); @(negedge clk);
            bus_din = (i >= 2 && i <= 5) ? 8'h77 : 8'hFF;
            checks++;
            if (core_ack !== (i == 7)) begin
                failures++;
                $display("FAIL rstmid_fresh_ack cyc=%0d got=%b", i, core_ack);
            end
            if (core_ack === 1'b1) begin
                core_req = 0;
                checks++;
                if (exp_q.size() == 0 || core_rdata !== exp_q[0]) begin
                    failures++;
                    $display("FAIL rstmid_fresh_rdata got=%h exp=77", core_rdata);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
        core_req = 0;
        bus_din = 8'hFF;
    endtask

    task automatic test_back_to_back();
        logic exp_busy;
        core_we = 0; core_addr = 16'h0600; core_req = 1;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        for (int i = 1; i <= 18; i++) begin
            @(posedge clk); @(negedge clk);
            bus_din = (i <= 7) ? 8'h11 : 8'h22;
            exp_busy = (i >= 1 && i <= 6) || (i >= 9 && i <= 14);
            checks++;
            if (busy !== exp_busy) begin
                failures++;
                $display("FAIL b2b_busy cyc=%0d got=%b exp=%b", i, busy, exp_busy);
            end
            checks++;
            if (core_ack !== (i == 7 || i == 15)) begin
                failures++;
                $display("FAIL b2b_ack cyc=%0d got=%b", i, core_ack);
            end
            if (core_ack === 1'b1) begin
                if (i == 15) core_req = 0;
                checks++;
                if (exp_q.size() == 0 || core_rdata !== exp_q[0]) begin
                    failures++;
                    $display("FAIL b2b_rdata cyc=%0d got=%h", i, core_rdata);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
        core_req = 0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL b2b_pending got=%0d exp=0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_core_read();
        test_dbg_write();
        test_arbitration();
        test_halt();
        test_reset_mid_write();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
